// File: rtl/ifu_pc_unit.sv
// ---------------------------------------------------------------------------
// ifu_pc_unit
//   Instruction-fetch front end of the single-cycle MIPS core. Holds the
//   program counter, drives the instruction-memory address every cycle and
//   selects the next PC from sequential flow, conditional branch, 26-bit
//   jump or register jump. A stall holds the PC and the retired-fetch
//   counter; pc_plus8 provides the jal/jalr link value.
//
// Optional feature (compile-time macro PC_RANGE_CHECK_EN):
//   When defined, a next-PC that is misaligned or outside the instruction
//   memory window [RESET_PC, RESET_PC + IM_DEPTH*4 - 4] raises a sticky
//   fault that freezes the PC and counter until reset. When undefined,
//   fault is tied to 0 and any next-PC is loaded.
//
// Parameters:
//   RESET_PC  - PC after reset; also the instruction-memory base address
//   IM_DEPTH  - instruction-memory depth in 32-bit words
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   stall      in   1   1 = hold PC and counter this edge
//   npc_op     in   2   00 PC+4, 01 branch, 10 jump imm26, 11 jump register
//   br_cond    in   1   branch-taken qualifier (npc_op = 01 only)
//   imm16      in  16   signed branch offset in words
//   imm26      in  26   jump target index
//   rs_val     in  32   jump-register target
//   pc         out 32   current PC (instruction-memory address)
//   pc_plus8   out 32   pc + 8, link value
//   npc        out 32   combinational next PC
//   fault      out  1   sticky fetch fault
//   fetch_cnt  out 32   PC advances since reset (wraps silently)
// ---------------------------------------------------------------------------
module ifu_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_cond,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic [31:0] npc,
    output logic        fault,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fault_q;
    logic        range_err;
    logic        advance;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;

    assign pc_plus4  = pc_q + 32'd4;
    // Word offset sign-extended and scaled to bytes.
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        npc = pc_plus4;
        unique case (npc_op_e'(npc_op))
            NPC_SEQ:    npc = pc_plus4;
            NPC_BRANCH: npc = br_cond ? (pc_plus4 + br_offset) : pc_plus4;
            NPC_JUMP:   npc = {pc_q[31:28], imm26, 2'b00};
            NPC_JR:     npc = rs_val;
            default:    npc = pc_plus4;
        endcase
    end

`ifdef PC_RANGE_CHECK_EN
    localparam logic [31:0] IM_LAST = RESET_PC + 32'(IM_DEPTH * 4) - 32'd4;

    assign range_err = (npc[1:0] != 2'b00) || (npc < RESET_PC) || (npc > IM_LAST);

    // Sticky: once set only reset clears it. A stalled edge leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (!stall && !fault_q && range_err) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign range_err = 1'b0;
    assign fault_q   = 1'b0;
`endif

    // An offending target is not loaded: the fault edge itself holds the PC.
    assign advance = !stall && !fault_q && !range_err;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (advance) begin
            pc_d  = npc;
            cnt_d = cnt_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= 32'd0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus8  = pc_q + 32'd8;
    assign fault     = fault_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ifu_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_ifu_pc_unit
//   Self-checking bench for ifu_pc_unit: a table of directed vectors with
//   hand-computed expected values, plus hand-written sequences for async
//   reset, jump from reset and the jump-register / range-fault cases.
// ---------------------------------------------------------------------------
module tb_ifu_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_cond;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic [31:0] npc;
    logic        fault;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    ifu_pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_op    (npc_op),
        .br_cond   (br_cond),
        .imm16     (imm16),
        .imm26     (imm26),
        .rs_val    (rs_val),
        .pc        (pc),
        .pc_plus8  (pc_plus8),
        .npc       (npc),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  npc_op;
        logic        br_cond;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] rs_val;
        logic [31:0] exp_npc;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] op, input logic bc,
                         input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] rs);
        stall   = s;
        npc_op  = op;
        br_cond = bc;
        imm16   = i16;
        imm26   = i26;
        rs_val  = rs;
    endtask

    // One rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from an edge, check the async reset values, release.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);

        //           stall op    bc    imm16     imm26        rs_val        npc            pc             cnt
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,       32'h0,        32'h0000_3004, 32'h0000_3004, 32'd1};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,       32'h0,        32'h0000_3008, 32'h0000_3008, 32'd2};
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 16'hFFFF, 26'h0,       32'h0,        32'h0000_3008, 32'h0000_3008, 32'd3};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 16'hFFFF, 26'h0,       32'h0,        32'h0000_300C, 32'h0000_300C, 32'd4};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 16'h0004, 26'h0,       32'h0,        32'h0000_3020, 32'h0000_3020, 32'd5};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 16'h0000, 26'h0000C10, 32'h0,        32'h0000_3040, 32'h0000_3020, 32'd5};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 16'h0000, 26'h0000C10, 32'h0,        32'h0000_3040, 32'h0000_3020, 32'd5};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 16'h0000, 26'h0000C10, 32'h0,        32'h0000_3040, 32'h0000_3040, 32'd6};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 16'h0000, 26'h0,       32'h0000_3100, 32'h0000_3100, 32'h0000_3100, 32'd7};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 16'hFFF0, 26'h0,       32'h0,        32'h0000_30C4, 32'h0000_30C4, 32'd8};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 16'h1234, 26'h3FFFFFF, 32'hDEAD_BEEF, 32'h0000_30C8, 32'h0000_30C8, 32'd9};

        // Table-driven main sequence from reset.
        do_reset();
        check("rst_pc_plus8", pc_plus8, 32'h0000_3008);
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].stall, vecs[i].npc_op, vecs[i].br_cond,
                  vecs[i].imm16, vecs[i].imm26, vecs[i].rs_val);
            #1;
            check($sformatf("v%0d_npc", i), npc, vecs[i].exp_npc);
            step();
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_cnt", i), fetch_cnt, vecs[i].exp_cnt);
            check($sformatf("v%0d_pc_plus8", i), pc_plus8, vecs[i].exp_pc + 32'd8);
            check($sformatf("v%0d_fault", i), {31'd0, fault}, 32'd0);
        end

        // Jump from reset: {pc[31:28], 26'h0000C10, 2'b00} = 32'h0000_3040.
        do_reset();
        drive(1'b0, 2'b10, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        step();
        check("jmp_rst_pc", pc, 32'h0000_3040);
        check("jmp_rst_cnt", fetch_cnt, 32'd1);

        // Free run to 32'h3010, then async reset mid-cycle.
        do_reset();
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        repeat (4) step();
        check("run_pc", pc, 32'h0000_3010);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'h0000_3000);
        check("async_rst_cnt", fetch_cnt, 32'd0);
        step();
        check("rst_held_pc", pc, 32'h0000_3000);
        check("rst_held_cnt", fetch_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Jump register to a target outside the window, then to a misaligned one.
        for (int k = 0; k < 2; k++) begin
            logic [31:0] tgt;
            tgt = (k == 0) ? 32'h0000_7000 : 32'h0000_3002;
            do_reset();
            drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, tgt);
            step();
`ifdef PC_RANGE_CHECK_EN
            check($sformatf("jr%0d_fault", k), {31'd0, fault}, 32'd1);
            check($sformatf("jr%0d_pc", k), pc, 32'h0000_3000);
            check($sformatf("jr%0d_cnt", k), fetch_cnt, 32'd0);
            drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
            repeat (3) step();
            check($sformatf("jr%0d_frozen_pc", k), pc, 32'h0000_3000);
            check($sformatf("jr%0d_frozen_cnt", k), fetch_cnt, 32'd0);
            check($sformatf("jr%0d_sticky", k), {31'd0, fault}, 32'd1);
            stall = 1'b1;
            step();
            check($sformatf("jr%0d_stall_fault", k), {31'd0, fault}, 32'd1);
            stall = 1'b0;
`else
            check($sformatf("jr%0d_fault", k), {31'd0, fault}, 32'd0);
            check($sformatf("jr%0d_pc", k), pc, tgt);
            check($sformatf("jr%0d_cnt", k), fetch_cnt, 32'd1);
`endif
        end
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time in case a sequence never returns.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
